// File: rtl/dds_cmd_pkg.sv
// rtl/dds_cmd_pkg.sv - shared constants, command codes and FSM states for dds_cmd_parser
// Purpose: frame header, command codes, parser state encoding and a command lookup helper.
// Ports: none (package).
package dds_cmd_pkg;

    localparam logic [7:0] HDR    = 8'h55;

    localparam logic [7:0] CMD_F1 = 8'h01;
    localparam logic [7:0] CMD_P1 = 8'h02;
    localparam logic [7:0] CMD_M1 = 8'h03;
    localparam logic [7:0] CMD_F2 = 8'h11;
    localparam logic [7:0] CMD_P2 = 8'h12;
    localparam logic [7:0] CMD_M2 = 8'h13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_PAY  = 2'd2,
        ST_CHK  = 2'd3
    } state_t;

    function automatic logic cmd_known(input logic [7:0] c);
        return (c == CMD_F1) || (c == CMD_P1) || (c == CMD_M1) ||
               (c == CMD_F2) || (c == CMD_P2) || (c == CMD_M2);
    endfunction

endpackage

// File: rtl/dds_cmd_parser_if.sv
// rtl/dds_cmd_parser_if.sv - received-byte stream from uart_rx into the command parser
// Purpose: groups the byte and its one-cycle valid strobe.
// Signals: Rx_Data (8, valid only with Rx_Done), Rx_Done (1, one-cycle strobe).
// Modports: master drives the stream (uart_rx side), slave consumes it (parser side).
interface dds_cmd_parser_if;
    logic [7:0] Rx_Data;
    logic       Rx_Done;

    modport master (output Rx_Data, output Rx_Done);
    modport slave  (input  Rx_Data, input  Rx_Done);
endinterface

// File: rtl/frame_timeout.sv
// rtl/frame_timeout.sv - inter-byte idle counter with one-cycle expiry flag
// Purpose: counts idle clocks while a frame is open; flags expiry at TIMEOUT_CYCLES-1.
// Ports: clk, rst (sync active-high), clr (byte seen, restarts count and blocks expiry),
//        en (frame open), expire (high for the cycle the limit is reached).
module frame_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 500_000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr || !en) begin
            cnt <= '0;
        end else if (cnt != LAST) begin
            cnt <= cnt + 1'b1;
        end
    end

    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign expire = en && !clr && (cnt == LAST);
endmodule

// File: rtl/dds_cmd_parser.sv
// rtl/dds_cmd_parser.sv - 7-byte host command frame parser driving two DDS channels
// Purpose: parses 55 CMD P3 P2 P1 P0 CHK frames and applies one register per verified frame.
// Ports: Clk, Reset (sync active-high), rx (byte stream, slave), Fword1/Pword1/Module_Sel1,
//        Fword2/Pword2/Module_Sel2 (registered channel controls), Cmd_Ok, Cmd_Err (one-cycle pulses).
module dds_cmd_parser
    import dds_cmd_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 500_000,
    parameter logic [31:0] FWORD_DEFAULT  = 32'd85899
) (
    input  logic             Clk,
    input  logic             Reset,
    dds_cmd_parser_if.slave  rx,
    output logic [31:0]      Fword1,
    output logic [11:0]      Pword1,
    output logic [1:0]       Module_Sel1,
    output logic [31:0]      Fword2,
    output logic [11:0]      Pword2,
    output logic [1:0]       Module_Sel2,
    output logic             Cmd_Ok,
    output logic             Cmd_Err
);
    state_t      state, state_next;
    logic [7:0]  cmd;
    logic [31:0] payload;
    logic [7:0]  xsum;
    logic [1:0]  idx;
    logic        expire;
    logic        do_apply;
    logic        do_err;

    frame_timeout #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_timeout (
        .clk    (Clk),
        .rst    (Reset),
        .clr    (rx.Rx_Done),
        .en     (state != ST_IDLE),
        .expire (expire)
    );

    always_ff @(posedge Clk) begin
        if (Reset) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        do_apply   = 1'b0;
        do_err     = 1'b0;
        case (state)
            ST_IDLE: if (rx.Rx_Done && rx.Rx_Data == HDR) state_next = ST_CMD;
            ST_CMD:  if (rx.Rx_Done) state_next = ST_PAY;
            ST_PAY:  if (rx.Rx_Done && idx == 2'd3) state_next = ST_CHK;
            ST_CHK: begin
                if (rx.Rx_Done) begin
                    state_next = ST_IDLE;
                    if (rx.Rx_Data == xsum && cmd_known(cmd)) do_apply = 1'b1;
                    else                                      do_err   = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
        // expire can only be high with no byte present, so it never collides with do_apply.
        if (expire) begin
            state_next = ST_IDLE;
            do_err     = 1'b1;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            cmd         <= '0;
            payload     <= '0;
            xsum        <= '0;
            idx         <= '0;
            Fword1      <= FWORD_DEFAULT;
            Pword1      <= '0;
            Module_Sel1 <= '0;
            Fword2      <= FWORD_DEFAULT;
            Pword2      <= '0;
            Module_Sel2 <= '0;
            Cmd_Ok      <= 1'b0;
            Cmd_Err     <= 1'b0;
        end else begin
            Cmd_Ok  <= do_apply;
            Cmd_Err <= do_err;
            if (rx.Rx_Done) begin
                case (state)
                    ST_CMD: begin
                        cmd  <= rx.Rx_Data;
                        xsum <= rx.Rx_Data;
                        idx  <= 2'd0;
                    end
                    ST_PAY: begin
                        payload <= {payload[23:0], rx.Rx_Data};
                        xsum    <= xsum ^ rx.Rx_Data;
                        idx     <= idx + 2'd1;
                    end
                    default: ;
                endcase
            end
            if (do_apply) begin
                case (cmd)
                    CMD_F1:  Fword1      <= payload;
                    CMD_P1:  Pword1      <= payload[11:0];
                    CMD_M1:  Module_Sel1 <= payload[1:0];
                    CMD_F2:  Fword2      <= payload;
                    CMD_P2:  Pword2      <= payload[11:0];
                    CMD_M2:  Module_Sel2 <= payload[1:0];
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dds_cmd_parser.sv
// tb/tb_dds_cmd_parser.sv - self-checking bench for dds_cmd_parser
module tb_dds_cmd_parser;
    localparam int TO = 100;
    localparam logic [31:0] FDEF = 32'd85899;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [31:0] Fword1, Fword2;
    logic [11:0] Pword1, Pword2;
    logic [1:0]  Module_Sel1, Module_Sel2;
    logic        Cmd_Ok, Cmd_Err;

    always #5 Clk = ~Clk;

    dds_cmd_parser_if rx ();

    dds_cmd_parser #(.TIMEOUT_CYCLES(TO), .FWORD_DEFAULT(FDEF)) dut (
        .Clk(Clk), .Reset(Reset), .rx(rx),
        .Fword1(Fword1), .Pword1(Pword1), .Module_Sel1(Module_Sel1),
        .Fword2(Fword2), .Pword2(Pword2), .Module_Sel2(Module_Sel2),
        .Cmd_Ok(Cmd_Ok), .Cmd_Err(Cmd_Err)
    );

    int checks = 0;
    int errors = 0;
    int ok_cnt = 0, err_cnt = 0, both_cnt = 0;

    always @(negedge Clk) begin
        if (Reset !== 1'b1) begin
            if (Cmd_Ok === 1'b1)  ok_cnt++;
            if (Cmd_Err === 1'b1) err_cnt++;
            if (Cmd_Ok === 1'b1 && Cmd_Err === 1'b1) both_cnt++;
        end
    end

    // reference register image
    logic [31:0] m_f1, m_f2;
    logic [11:0] m_p1, m_p2;
    logic [1:0]  m_m1, m_m2;

    typedef struct {
        logic [55:0] frame;
        bit          ok;
        logic [31:0] f1;
        logic [11:0] p1;
        logic [1:0]  m1;
        logic [31:0] f2;
        logic [11:0] p2;
        logic [1:0]  m2;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_regs(input string tag, input logic [31:0] f1, input logic [11:0] p1,
                              input logic [1:0] m1, input logic [31:0] f2,
                              input logic [11:0] p2, input logic [1:0] m2);
        chk({tag, "_f1"}, Fword1, f1);
        chk({tag, "_p1"}, {20'd0, Pword1}, {20'd0, p1});
        chk({tag, "_m1"}, {30'd0, Module_Sel1}, {30'd0, m1});
        chk({tag, "_f2"}, Fword2, f2);
        chk({tag, "_p2"}, {20'd0, Pword2}, {20'd0, p2});
        chk({tag, "_m2"}, {30'd0, Module_Sel2}, {30'd0, m2});
    endtask

    task automatic check_model(input string tag);
        check_regs(tag, m_f1, m_p1, m_m1, m_f2, m_p2, m_m2);
    endtask

    task automatic model_reset();
        m_f1 = FDEF; m_p1 = '0; m_m1 = '0;
        m_f2 = FDEF; m_p2 = '0; m_m2 = '0;
    endtask

    // Frame-level reference: accept when XOR of CMD..P0 equals CHK and CMD is one of the six codes.
    task automatic model_frame(input logic [55:0] fr, output bit ok);
        logic [7:0]  c, k;
        logic [31:0] p;
        c = fr[47:40];
        p = fr[39:8];
        k = fr[7:0];
        ok = (k == (c ^ p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0])) &&
             (c inside {8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13});
        if (ok) begin
            case (c)
                8'h01: m_f1 = p;
                8'h02: m_p1 = p[11:0];
                8'h03: m_m1 = p[1:0];
                8'h11: m_f2 = p;
                8'h12: m_p2 = p[11:0];
                8'h13: m_m2 = p[1:0];
                default: ;
            endcase
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) @(negedge Clk);
        @(negedge Clk);
        rx.Rx_Data = b;
        rx.Rx_Done = 1'b1;
        @(negedge Clk);
        rx.Rx_Done = 1'b0;
    endtask

    task automatic send_frame(input string tag, input logic [55:0] fr, input int maxgap, input bit exp_ok);
        int o0, e0;
        o0 = ok_cnt;
        e0 = err_cnt;
        for (int i = 0; i < 7; i++)
            send_byte(fr[55-8*i -: 8], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
        chk({tag, "_ok_lat"},  {31'd0, Cmd_Ok},  {31'd0, exp_ok});
        chk({tag, "_err_lat"}, {31'd0, Cmd_Err}, {31'd0, !exp_ok});
        repeat (2) @(negedge Clk);
        chk({tag, "_ok_cnt"},  ok_cnt - o0,  {31'd0, exp_ok});
        chk({tag, "_err_cnt"}, err_cnt - e0, {31'd0, !exp_ok});
    endtask

    initial begin
        bit ok;
        int e_before, o_before;
        logic [7:0] codes [8];
        logic [7:0] c, nb;
        logic [31:0] p;
        logic [7:0] k;

        vecs[0] = '{56'h55_01_00_83_12_6F_FE, 1'b0, FDEF,         12'h000, 2'd0, FDEF,       12'h000, 2'd0};
        vecs[1] = '{56'h55_7F_00_00_00_00_7F, 1'b0, FDEF,         12'h000, 2'd0, FDEF,       12'h000, 2'd0};
        vecs[2] = '{56'h55_01_00_83_12_6F_FF, 1'b1, 32'h0083126F, 12'h000, 2'd0, FDEF,       12'h000, 2'd0};
        vecs[3] = '{56'h55_02_00_00_0C_00_0E, 1'b1, 32'h0083126F, 12'd3072, 2'd0, FDEF,      12'h000, 2'd0};
        vecs[4] = '{56'h55_13_00_00_00_02_11, 1'b1, 32'h0083126F, 12'd3072, 2'd0, FDEF,      12'h000, 2'd2};
        vecs[5] = '{56'h55_11_00_00_01_00_10, 1'b1, 32'h0083126F, 12'd3072, 2'd0, 32'd256,   12'h000, 2'd2};
        vecs[6] = '{56'h55_03_55_55_55_57_01, 1'b1, 32'h0083126F, 12'd3072, 2'd3, 32'd256,   12'h000, 2'd2};
        vecs[7] = '{56'h55_12_00_00_0F_FF_E2, 1'b1, 32'h0083126F, 12'd3072, 2'd3, 32'd256,   12'hFFF, 2'd2};

        rx.Rx_Data = 8'h00;
        rx.Rx_Done = 1'b0;
        Reset = 1'b1;
        repeat (3) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        chk("rst_ok",  {31'd0, Cmd_Ok},  32'd0);
        chk("rst_err", {31'd0, Cmd_Err}, 32'd0);
        check_regs("rst", FDEF, 12'd0, 2'd0, FDEF, 12'd0, 2'd0);

        // fixed vectors
        for (int v = 0; v < 8; v++) begin
            send_frame($sformatf("vec%0d", v), vecs[v].frame, v % 2, vecs[v].ok);
            check_regs($sformatf("vec%0d", v), vecs[v].f1, vecs[v].p1, vecs[v].m1,
                       vecs[v].f2, vecs[v].p2, vecs[v].m2);
        end

        // timeout fires exactly TO idle clocks after the last byte
        send_byte(8'h55, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        repeat (TO - 1) @(negedge Clk);
        chk("to_early", {31'd0, Cmd_Err}, 32'd0);
        @(negedge Clk);
        chk("to_expire", {31'd0, Cmd_Err}, 32'd1);
        @(negedge Clk);
        chk("to_pulse_len", {31'd0, Cmd_Err}, 32'd0);
        check_regs("to_hold", 32'h0083126F, 12'd3072, 2'd3, 32'd256, 12'hFFF, 2'd2);
        send_frame("to_after", 56'h55_01_00_00_12_34_27, 0, 1'b1);
        chk("to_after_f1", Fword1, 32'h00001234);

        // byte landing in the expiry cycle cancels the timeout
        e_before = err_cnt;
        o_before = ok_cnt;
        send_byte(8'h55, 0); send_byte(8'h01, 0); send_byte(8'h00, 0);
        repeat (TO - 2) @(negedge Clk);
        send_byte(8'h00, 0);
        send_byte(8'hAB, 0); send_byte(8'hCD, 0); send_byte(8'h67, 0);
        repeat (3) @(negedge Clk);
        chk("cancel_err", err_cnt - e_before, 32'd0);
        chk("cancel_ok",  ok_cnt - o_before, 32'd1);
        chk("cancel_f1",  Fword1, 32'h0000ABCD);

        // reset mid-frame, then noise before a full frame
        send_byte(8'h55, 0); send_byte(8'h11, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("midrst_ok",  {31'd0, Cmd_Ok},  32'd0);
        chk("midrst_err", {31'd0, Cmd_Err}, 32'd0);
        model_reset();
        check_model("midrst");
        e_before = err_cnt;
        send_byte(8'hAA, 0);
        send_byte(8'h12, 1);
        model_frame(56'h55_11_00_00_01_00_10, ok);
        send_frame("postrst", 56'h55_11_00_00_01_00_10, 0, ok);
        chk("postrst_f2", Fword2, 32'd256);
        chk("noise_err", err_cnt - e_before, 32'd0);
        check_model("postrst");

        // randomized frames vs. reference
        codes = '{8'h01, 8'h02, 8'h03, 8'h11, 8'h12, 8'h13, 8'h7F, 8'h00};
        for (int n = 0; n < 40; n++) begin
            c = codes[$urandom_range(0, 7)];
            if (c == 8'h00) c = 8'($urandom);
            p = $urandom;
            k = c ^ p[31:24] ^ p[23:16] ^ p[15:8] ^ p[7:0];
            if ($urandom_range(0, 4) == 0) k = k ^ 8'($urandom_range(1, 255));
            e_before = err_cnt;
            for (int j = $urandom_range(0, 2); j > 0; j--) begin
                nb = 8'($urandom);
                if (nb == 8'h55) nb = 8'hAA;
                send_byte(nb, $urandom_range(0, 2));
            end
            model_frame({8'h55, c, p, k}, ok);
            send_frame($sformatf("rnd%0d", n), {8'h55, c, p, k}, 3, ok);
            chk($sformatf("rnd%0d_err_total", n), err_cnt - e_before, {31'd0, !ok});
            check_model($sformatf("rnd%0d", n));
        end

        chk("ok_err_overlap", both_cnt, 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
